// File: rtl/simple_bus_pkg.sv
// Shared types and sizing helpers for the simple bus bridge and its address decoder.
package simple_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Upper address bits needed to name NS slaves.
  function automatic int unsigned sel_w(input int unsigned ns);
    if (ns < 2) return 1;
    return $clog2(ns);
  endfunction

  // Counter wide enough to hold the value TIMEOUT itself.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/simple_bus_decoder.sv
// Slave address decoder: slave-select field -> one-hot slave request plus a miss flag for
// select values with no slave behind them (only possible when NS is not a power of two).
module simple_bus_decoder
  import simple_bus_pkg::*;
#(
  parameter int unsigned NS   = 4,
  parameter int unsigned SelW = sel_w(NS)
) (
  input  logic [SelW-1:0] i_sel_field,
  output logic [NS-1:0]   o_sel,
  output logic            o_miss
);

  always_comb begin
    o_sel = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      o_sel[i] = (i_sel_field == SelW'(i));
    end
  end

  assign o_miss = ~|o_sel;

endmodule

// File: rtl/simple_bus_bridge.sv
// Single-master to NS-slave bus bridge: one transaction in flight, decode-miss error response,
// optional wait-state timeout compiled in with SIMPLE_BUS_TIMEOUT_EN.
module simple_bus_bridge
  import simple_bus_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter int unsigned NS      = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_m_req,
  input  logic             i_m_rw,
  input  logic [AW-1:0]    i_m_addr,
  input  logic [DW-1:0]    i_m_wdata,
  output logic             o_m_ready,
  output logic [DW-1:0]    o_m_rdata,
  output logic             o_m_valid,
  output logic             o_m_err,
  output logic [NS-1:0]    o_s_req,
  output logic             o_s_rw,
  output logic [AW-1:0]    o_s_addr,
  output logic [DW-1:0]    o_s_wdata,
  input  logic [NS*DW-1:0] i_s_rdata,
  input  logic [NS-1:0]    i_s_valid
);

  localparam int unsigned SelW = sel_w(NS);

  state_e        r_state, w_state_d;
  logic [NS-1:0] r_s_req, w_s_req_d;
  logic          r_s_rw, w_s_rw_d;
  logic [AW-1:0] r_s_addr, w_s_addr_d;
  logic [DW-1:0] r_s_wdata, w_s_wdata_d;
  logic [DW-1:0] r_m_rdata, w_m_rdata_d;
  logic          r_m_valid, w_m_valid_d;
  logic          r_m_err, w_m_err_d;

  logic [NS-1:0] w_dec_sel;
  logic          w_dec_miss;
  logic          w_accept;
  logic          w_sel_valid;
  logic [DW-1:0] w_sel_rdata;
  logic          w_expire;

  simple_bus_decoder #(
    .NS   (NS),
    .SelW (SelW)
  ) u_decoder (
    .i_sel_field (i_m_addr[AW-1 -: SelW]),
    .o_sel       (w_dec_sel),
    .o_miss      (w_dec_miss)
  );

  assign o_m_ready = (r_state == StIdle) & ~i_rst;
  assign w_accept  = i_m_req & o_m_ready;

  // The held one-hot request masks out handshakes and data from non-selected slaves.
  assign w_sel_valid = |(r_s_req & i_s_valid);

  always_comb begin
    w_sel_rdata = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (r_s_req[i]) begin
        w_sel_rdata = w_sel_rdata | i_s_rdata[i*DW +: DW];
      end
    end
  end

`ifdef SIMPLE_BUS_TIMEOUT_EN
  localparam int unsigned CntW = cnt_w(TIMEOUT);

  logic [CntW-1:0] r_cnt, w_cnt_d;

  // Expiry is the WAIT cycle whose increment would bring the count to TIMEOUT.
  assign w_expire = (r_cnt == CntW'(TIMEOUT - 1));

  always_comb begin
    w_cnt_d = r_cnt;
    if (r_state == StIdle) begin
      w_cnt_d = '0;
    end else if ((r_state == StWait) && !w_sel_valid) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_s_req_d   = r_s_req;
    w_s_rw_d    = r_s_rw;
    w_s_addr_d  = r_s_addr;
    w_s_wdata_d = r_s_wdata;
    w_m_rdata_d = '0;
    w_m_valid_d = 1'b0;
    w_m_err_d   = RESP_OK;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_s_rw_d    = i_m_rw;
          w_s_addr_d  = i_m_addr;
          w_s_wdata_d = i_m_wdata;
          if (w_dec_miss) begin
            w_state_d   = StResp;
            w_m_valid_d = 1'b1;
            w_m_err_d   = RESP_ERR;
          end else begin
            w_s_req_d = w_dec_sel;
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        // A completing slave beats a simultaneous expiry.
        if (w_sel_valid) begin
          w_s_req_d   = '0;
          w_state_d   = StResp;
          w_m_valid_d = 1'b1;
          w_m_rdata_d = r_s_rw ? w_sel_rdata : '0;
          w_m_err_d   = RESP_OK;
        end else if (w_expire) begin
          w_s_req_d   = '0;
          w_state_d   = StResp;
          w_m_valid_d = 1'b1;
          w_m_err_d   = RESP_ERR;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_s_req_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_s_req   <= '0;
      r_s_rw    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_rdata <= '0;
      r_m_valid <= 1'b0;
      r_m_err   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_s_req   <= w_s_req_d;
      r_s_rw    <= w_s_rw_d;
      r_s_addr  <= w_s_addr_d;
      r_s_wdata <= w_s_wdata_d;
      r_m_rdata <= w_m_rdata_d;
      r_m_valid <= w_m_valid_d;
      r_m_err   <= w_m_err_d;
    end
  end

  assign o_s_req   = r_s_req;
  assign o_s_rw    = r_s_rw;
  assign o_s_addr  = r_s_addr;
  assign o_s_wdata = r_s_wdata;
  assign o_m_rdata = r_m_rdata;
  assign o_m_valid = r_m_valid;
  assign o_m_err   = r_m_err;

endmodule

// File: tb/tb_simple_bus_bridge.sv
// Bench for simple_bus_bridge: NS=4 main instance plus an NS=3 instance for decode misses;
// responses are scoreboarded by expected data, error flag and arrival cycle.
module tb_simple_bus_bridge;

  typedef struct {
    logic [7:0]  rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q4[$];
  exp_t q3[$];

  // NS=4 instance
  logic        m_req = 1'b0, m_rw = 1'b0;
  logic [7:0]  m_addr = '0, m_wdata = '0;
  logic        m_ready, m_valid, m_err, s_rw;
  logic [7:0]  m_rdata, s_addr, s_wdata;
  logic [3:0]  s_req;
  logic [31:0] s_rdata = '0;
  logic [3:0]  s_valid = '0;

  // NS=3 instance
  logic        m_req3 = 1'b0, m_rw3 = 1'b0;
  logic [7:0]  m_addr3 = '0, m_wdata3 = '0;
  logic        m_ready3, m_valid3, m_err3, s_rw3;
  logic [7:0]  m_rdata3, s_addr3, s_wdata3;
  logic [2:0]  s_req3;
  logic [23:0] s_rdata3 = '0;
  logic [2:0]  s_valid3 = '0;

  simple_bus_bridge #(.AW(8), .DW(8), .NS(4), .TIMEOUT(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_m_req(m_req), .i_m_rw(m_rw), .i_m_addr(m_addr),
    .i_m_wdata(m_wdata), .o_m_ready(m_ready), .o_m_rdata(m_rdata), .o_m_valid(m_valid),
    .o_m_err(m_err), .o_s_req(s_req), .o_s_rw(s_rw), .o_s_addr(s_addr),
    .o_s_wdata(s_wdata), .i_s_rdata(s_rdata), .i_s_valid(s_valid)
  );

  simple_bus_bridge #(.AW(8), .DW(8), .NS(3), .TIMEOUT(16)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_m_req(m_req3), .i_m_rw(m_rw3), .i_m_addr(m_addr3),
    .i_m_wdata(m_wdata3), .o_m_ready(m_ready3), .o_m_rdata(m_rdata3), .o_m_valid(m_valid3),
    .o_m_err(m_err3), .o_s_req(s_req3), .o_s_rw(s_rw3), .o_s_addr(s_addr3),
    .o_s_wdata(s_wdata3), .i_s_rdata(s_rdata3), .i_s_valid(s_valid3)
  );

  // Response monitors sample 1 time unit after each edge; stimulus moves at 2.
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (m_valid === 1'b1) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL resp4_unexpected: m_valid=1 rdata=%h err=%b at cycle %0d, required none",
                 m_rdata, m_err, cyc);
      end else begin
        e = q4.pop_front();
        if ({m_rdata, m_err, cyc} !== {e.rdata, e.err, e.cyc}) begin
          n_fail++;
          $display("FAIL resp4: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   m_rdata, m_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  always begin
    exp_t e;
    @(posedge clk); #1;
    if (m_valid3 === 1'b1) begin
      n_checks++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL resp3_unexpected: m_valid=1 at cycle %0d, required none", cyc);
      end else begin
        e = q3.pop_front();
        if ({m_rdata3, m_err3, cyc} !== {e.rdata, e.err, e.cyc}) begin
          n_fail++;
          $display("FAIL resp3: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   m_rdata3, m_err3, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push4(input logic [7:0] rdata, input logic err, input int unsigned c);
    exp_t e;
    e.rdata = rdata; e.err = err; e.cyc = c;
    q4.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({s_req, s_rw, s_addr, s_wdata, m_rdata, m_valid, m_err, m_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b rw=%b addr=%h wd=%h rd=%h v=%b e=%b rdy=%b, required 0",
               s_req, s_rw, s_addr, s_wdata, m_rdata, m_valid, m_err, m_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_ready !== 1'b1 || m_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b/%b, required 1/1", m_ready, m_ready3);
    end
    tick();
  endtask

  task automatic test_read();
    int unsigned acc;
    s_rdata = {8'h11, 8'h3C, 8'h22, 8'h33};
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'h85; m_wdata = 8'hEE;
    acc = cyc + 1;
    push4(8'h3C, 1'b0, acc + 3);
    tick();
    m_req = 1'b0;
    n_checks++;
    if ({s_req, s_rw, s_addr, m_ready} !== {4'b0100, 1'b1, 8'h85, 1'b0}) begin
      n_fail++;
      $display("FAIL read_issue: got req=%b rw=%b addr=%h rdy=%b, required 0100 1 85 0",
               s_req, s_rw, s_addr, m_ready);
    end
    repeat (2) begin
      tick();
      n_checks++;
      if (s_req !== 4'b0100) begin
        n_fail++;
        $display("FAIL read_hold: got s_req=%b, required 0100", s_req);
      end
    end
    s_valid = 4'b0100;
    tick();
    s_valid = 4'b0000;
    n_checks++;
    if (s_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_release: got s_req=%b, required 0000", s_req);
    end
    tick();
    n_checks++;
    if ({m_valid, m_rdata, m_err, m_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL read_idle: got v=%b rd=%h e=%b rdy=%b, required 0 00 0 1",
               m_valid, m_rdata, m_err, m_ready);
    end
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL read_drain: %0d responses outstanding, required 0", q4.size());
    end
  endtask

  task automatic test_write();
    int unsigned acc;
    s_rdata = {8'h44, 8'h55, 8'h66, 8'h77};
    m_req = 1'b1; m_rw = 1'b0; m_addr = 8'h10; m_wdata = 8'hA5;
    acc = cyc + 1;
    push4(8'h00, 1'b0, acc + 1);
    tick();
    m_req = 1'b0;
    n_checks++;
    if ({s_req, s_rw, s_addr, s_wdata} !== {4'b0001, 1'b0, 8'h10, 8'hA5}) begin
      n_fail++;
      $display("FAIL write_issue: got req=%b rw=%b addr=%h wd=%h, required 0001 0 10 a5",
               s_req, s_rw, s_addr, s_wdata);
    end
    s_valid = 4'b0001;
    tick();
    s_valid = 4'b0000;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL write_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask

  task automatic test_decode_miss();
    exp_t e;
    int unsigned acc;
    m_req3 = 1'b1; m_rw3 = 1'b1; m_addr3 = 8'hC0;
    acc = cyc + 1;
    e.rdata = 8'h00; e.err = 1'b1; e.cyc = acc;
    q3.push_back(e);
    tick();
    m_req3 = 1'b0;
    n_checks++;
    if ({s_req3, m_ready3} !== 4'b0000) begin
      n_fail++;
      $display("FAIL miss_issue: got s_req=%b rdy=%b, required 000 0", s_req3, m_ready3);
    end
    tick();
    n_checks++;
    if ({m_ready3, m_valid3, m_err3} !== 3'b100) begin
      n_fail++;
      $display("FAIL miss_idle: got rdy=%b v=%b e=%b, required 1 0 0", m_ready3, m_valid3, m_err3);
    end
    // A mapped slave on the same instance still works.
    s_rdata3 = {8'hC7, 8'h01, 8'h02};
    m_req3 = 1'b1; m_addr3 = 8'h80;
    acc = cyc + 1;
    e.rdata = 8'hC7; e.err = 1'b0; e.cyc = acc + 1;
    q3.push_back(e);
    tick();
    m_req3 = 1'b0;
    s_valid3 = 3'b100;
    tick();
    s_valid3 = 3'b000;
    for (int i = 0; i < 20 && q3.size() != 0; i++) tick();
    n_checks++;
    if (q3.size() != 0) begin
      n_fail++;
      $display("FAIL miss_drain: %0d responses outstanding, required 0", q3.size());
    end
    tick();
  endtask

  task automatic test_wrong_slave();
    int unsigned acc1;
    int unsigned acc2;
    s_rdata = {8'hD3, 8'h22, 8'h5A, 8'hB0};
    s_valid = 4'b0010;
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'hC4;
    acc1 = cyc + 1;
    acc2 = acc1 + 6;
    push4(8'hD3, 1'b0, acc1 + 4);
    push4(8'h5A, 1'b0, acc2 + 1);
    tick();
    m_addr = 8'h40;
    s_valid = 4'b0011;
    tick();
    s_valid = 4'b0010;
    n_checks++;
    if ({s_req, m_ready} !== {4'b1000, 1'b0}) begin
      n_fail++;
      $display("FAIL wrong_hold: got s_req=%b rdy=%b, required 1000 0", s_req, m_ready);
    end
    tick(); tick();
    s_valid = 4'b1010;
    tick();
    s_valid = 4'b0010;
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrong_resp_ready: got m_ready=%b, required 0", m_ready);
    end
    tick();
    n_checks++;
    if ({s_req, m_ready} !== {4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL wrong_idle: got s_req=%b rdy=%b, required 0000 1", s_req, m_ready);
    end
    tick();
    m_req = 1'b0;
    n_checks++;
    if ({s_req, s_addr} !== {4'b0010, 8'h40}) begin
      n_fail++;
      $display("FAIL wrong_second: got s_req=%b addr=%h, required 0010 40", s_req, s_addr);
    end
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    s_valid = 4'b0000;
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL wrong_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned acc;
    logic exp_rdy;
    s_rdata = {8'h00, 8'h99, 8'h00, 8'h00};
    s_valid = 4'b0100;
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'h80;
    acc = cyc + 1;
    for (int i = 0; i < 4; i++) push4(8'h99, 1'b0, acc + 1 + 3 * i);
    tick();
    while (cyc < acc + 9) begin
      tick();
      exp_rdy = (((cyc - acc) % 3) == 2);
      n_checks++;
      if (m_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_ready: cycle %0d got m_ready=%b, required %b", cyc, m_ready, exp_rdy);
      end
    end
    m_req = 1'b0;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    s_valid = 4'b0000;
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int unsigned acc;
    s_rdata = {8'h12, 8'h34, 8'h6E, 8'h78};
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'hC0; m_wdata = 8'h5F;
    tick();
    m_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({s_req, s_rw, s_addr, s_wdata, m_rdata, m_valid, m_err, m_ready} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: got req=%b rw=%b addr=%h wd=%h rd=%h v=%b e=%b rdy=%b, required 0",
               s_req, s_rw, s_addr, s_wdata, m_rdata, m_valid, m_err, m_ready);
    end
    rst = 1'b0;
    s_valid = 4'b1000;
    tick();
    s_valid = 4'b0000;
    tick();
    m_req = 1'b1; m_addr = 8'h41;
    acc = cyc + 1;
    push4(8'h6E, 1'b0, acc + 2);
    tick();
    m_req = 1'b0;
    tick();
    s_valid = 4'b0010;
    tick();
    s_valid = 4'b0000;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL rst_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask

`ifdef SIMPLE_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned acc;
    s_rdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'h40;
    acc = cyc + 1;
    push4(8'h00, 1'b1, acc + 16);
    tick();
    m_req = 1'b0;
    while (cyc < acc + 15) tick();
    n_checks++;
    if (s_req !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout_hold: got s_req=%b, required 0010", s_req);
    end
    tick();
    n_checks++;
    if (s_req !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_release: got s_req=%b, required 0000", s_req);
    end
    tick(); tick();
    // Completion on the expiry cycle gives a normal response.
    m_req = 1'b1;
    acc = cyc + 1;
    push4(8'h5A, 1'b0, acc + 16);
    tick();
    m_req = 1'b0;
    while (cyc < acc + 15) tick();
    s_valid = 4'b0010;
    tick();
    s_valid = 4'b0000;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask
`else
  task automatic test_timeout();
    int unsigned acc;
    s_rdata = {8'h00, 8'h00, 8'h5A, 8'h00};
    m_req = 1'b1; m_rw = 1'b1; m_addr = 8'h40;
    acc = cyc + 1;
    push4(8'h5A, 1'b0, acc + 41);
    tick();
    m_req = 1'b0;
    while (cyc < acc + 40) tick();
    n_checks++;
    if ({s_req, m_ready} !== {4'b0010, 1'b0}) begin
      n_fail++;
      $display("FAIL no_timeout_hold: got s_req=%b rdy=%b, required 0010 0", s_req, m_ready);
    end
    s_valid = 4'b0010;
    tick();
    s_valid = 4'b0000;
    for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
    n_checks++;
    if (q4.size() != 0) begin
      n_fail++;
      $display("FAIL no_timeout_drain: %0d responses outstanding, required 0", q4.size());
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_miss();
    test_wrong_slave();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
